// File: rtl/mvm_stream_ctrl_pkg.sv
// Shared types for the mvm streaming controller: FSM state encoding and
// the index-width helper used to size element counters.
package mvm_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        LOAD_M = 3'd0,
        LOAD_V = 3'd1,
        CLEAR  = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_stream_ctrl_if.sv
// Element streams of the mvm controller: operand input stream (with the
// matrix-reuse hint) and result output stream.
interface mvm_stream_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             reuse_matrix;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, reuse_matrix, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, reuse_matrix, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mvm_stream_ctrl_packer.sv
// Shift-in packer: each accepted element enters at the LSB end, so element 0
// ends up in the MSB slot after COUNT shifts. full flags that the next shift
// completes the set.
module mvm_stream_ctrl_packer
    import mvm_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift_en,
    input  logic [WIDTH-1:0]       data,
    output logic [COUNT*WIDTH-1:0] packed_data,
    output logic                   full
);

    localparam int CW = idx_width(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [COUNT*WIDTH-1:0] packed_r;
    logic [COUNT*WIDTH-1:0] shifted_s;
    logic [CW-1:0]          count_r;
    logic                   full_r;

    generate
        if (COUNT > 1) begin : g_multi
            assign shifted_s = {packed_r[(COUNT-1)*WIDTH-1:0], data};
        end else begin : g_single
            assign shifted_s = data;
        end
    endgenerate

    // Element register and beat counter; count wraps to 0 on the final beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            packed_r <= '0;
            count_r  <= '0;
            full_r   <= (COUNT == 1);
        end else if (shift_en) begin
            packed_r <= shifted_s;
            if (full_r) begin
                count_r <= '0;
                full_r  <= (COUNT == 1);
            end else begin
                count_r <= count_r + CW'(1'b1);
                full_r  <= ((count_r + CW'(1'b1)) == LAST);
            end
        end else begin
            packed_r <= packed_r;
            count_r  <= count_r;
            full_r   <= full_r;
        end
    end

    assign packed_data = packed_r;
    assign full        = full_r;

endmodule

// File: rtl/mvm_stream_ctrl.sv
// Streaming front/back end for an mvm instance: packs operand beats, runs
// clear/start/done, drains results. Optional MVM_STREAM_RELU_EN clamps
// negative results to zero at capture.
module mvm_stream_ctrl
    import mvm_stream_ctrl_pkg::*;
#(
    parameter int MATRIX_ROWS = 3,
    parameter int SHARED_DIM  = 3,
    parameter int WIDTH       = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    mvm_stream_ctrl_if.slave                      stream,
    output logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] mvm_matrix,
    output logic [SHARED_DIM*WIDTH-1:0]           mvm_vector,
    output logic                                  mvm_clear,
    output logic                                  mvm_start,
    input  logic                                  mvm_done,
    input  logic [MATRIX_ROWS*WIDTH-1:0]          mvm_result,
    output logic                                  busy
);

    localparam int RW = idx_width(MATRIX_ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(MATRIX_ROWS - 1);

    state_t           state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             busy_r;
    logic             clear_r;
    logic             start_r;
    logic             matrix_loaded_r;
    logic [RW-1:0]    row_idx_r;
    logic [WIDTH-1:0] result_r [MATRIX_ROWS];
    logic [WIDTH-1:0] cap_s    [MATRIX_ROWS];

    logic in_fire_s, out_fire_s, m_shift_s, v_shift_s, m_full_s, v_full_s;

    function automatic logic [WIDTH-1:0] relu_f(input logic [WIDTH-1:0] v);
`ifdef MVM_STREAM_RELU_EN
        return v[WIDTH-1] ? {WIDTH{1'b0}} : v;
`else
        return v;
`endif
    endfunction

    assign in_fire_s  = stream.in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & stream.out_ready;
    assign m_shift_s  = in_fire_s & (state_r == LOAD_M);
    assign v_shift_s  = in_fire_s & (state_r == LOAD_V);

    mvm_stream_ctrl_packer #(.WIDTH(WIDTH), .COUNT(MATRIX_ROWS*SHARED_DIM)) u_matrix (
        .clk(clk), .reset(reset), .shift_en(m_shift_s), .data(stream.in_data),
        .packed_data(mvm_matrix), .full(m_full_s)
    );

    mvm_stream_ctrl_packer #(.WIDTH(WIDTH), .COUNT(SHARED_DIM)) u_vector (
        .clk(clk), .reset(reset), .shift_en(v_shift_s), .data(stream.in_data),
        .packed_data(mvm_vector), .full(v_full_s)
    );

    // Row r of the result bus sits r slots below the MSB end.
    always_comb begin
        for (int r = 0; r < MATRIX_ROWS; r++) begin
            cap_s[r] = relu_f(mvm_result[(MATRIX_ROWS-r)*WIDTH-1 -: WIDTH]);
        end
    end

    // Controller FSM; every outward-facing flag is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= LOAD_M;
            in_ready_r      <= 1'b0;
            out_valid_r     <= 1'b0;
            out_data_r      <= '0;
            busy_r          <= 1'b0;
            clear_r         <= 1'b0;
            start_r         <= 1'b0;
            matrix_loaded_r <= 1'b0;
            row_idx_r       <= '0;
            for (int r = 0; r < MATRIX_ROWS; r++) result_r[r] <= '0;
        end else begin
            clear_r <= 1'b0;
            start_r <= 1'b0;
            case (state_r)
                LOAD_M: begin
                    in_ready_r <= 1'b1;
                    if (in_fire_s) begin
                        busy_r <= 1'b1;
                        if (m_full_s) begin
                            matrix_loaded_r <= 1'b1;
                            state_r         <= LOAD_V;
                        end
                    end
                end
                LOAD_V: begin
                    in_ready_r <= 1'b1;
                    if (in_fire_s) begin
                        busy_r <= 1'b1;
                        if (v_full_s) begin
                            in_ready_r <= 1'b0;
                            clear_r    <= 1'b1;
                            state_r    <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    start_r <= 1'b1;
                    state_r <= START;
                end
                START: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (mvm_done) begin
                        for (int r = 0; r < MATRIX_ROWS; r++) result_r[r] <= cap_s[r];
                        out_data_r  <= cap_s[0];
                        out_valid_r <= 1'b1;
                        row_idx_r   <= '0;
                        state_r     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire_s) begin
                        if (row_idx_r == LAST_ROW) begin
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                            in_ready_r  <= 1'b1;
                            row_idx_r   <= '0;
                            state_r     <= (stream.reuse_matrix && matrix_loaded_r) ? LOAD_V : LOAD_M;
                        end else begin
                            row_idx_r  <= row_idx_r + RW'(1'b1);
                            out_data_r <= result_r[row_idx_r + RW'(1'b1)];
                        end
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= LOAD_M;
                end
            endcase
        end
    end

    assign stream.in_ready  = in_ready_r;
    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign mvm_clear        = clear_r;
    assign mvm_start        = start_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_mvm_stream_ctrl.sv
// Bench for mvm_stream_ctrl: a 3x3 and a 2x4 instance, each with a behavioural
// mvm responder, checked against dot products computed from the sent elements.
module tb_mvm_stream_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       sel_b;
    logic       in_valid_d, out_ready_d, reuse_d;
    logic [7:0] in_data_d;

    mvm_stream_ctrl_if #(.WIDTH(8)) sa ();
    mvm_stream_ctrl_if #(.WIDTH(8)) sb ();

    assign sa.in_valid     = in_valid_d & ~sel_b;
    assign sa.in_data      = in_data_d;
    assign sa.reuse_matrix = reuse_d;
    assign sa.out_ready    = out_ready_d & ~sel_b;
    assign sb.in_valid     = in_valid_d & sel_b;
    assign sb.in_data      = in_data_d;
    assign sb.reuse_matrix = reuse_d;
    assign sb.out_ready    = out_ready_d & sel_b;

    logic [71:0] a_mat; logic [23:0] a_vec; logic [23:0] a_res = '0;
    logic a_clear, a_start, a_done = 1'b0, a_busy;
    logic [63:0] b_mat; logic [31:0] b_vec; logic [15:0] b_res = '0;
    logic b_clear, b_start, b_done = 1'b0, b_busy;

    mvm_stream_ctrl #(.MATRIX_ROWS(3), .SHARED_DIM(3), .WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .stream(sa),
        .mvm_matrix(a_mat), .mvm_vector(a_vec), .mvm_clear(a_clear), .mvm_start(a_start),
        .mvm_done(a_done), .mvm_result(a_res), .busy(a_busy)
    );

    mvm_stream_ctrl #(.MATRIX_ROWS(2), .SHARED_DIM(4), .WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .stream(sb),
        .mvm_matrix(b_mat), .mvm_vector(b_vec), .mvm_clear(b_clear), .mvm_start(b_start),
        .mvm_done(b_done), .mvm_result(b_res), .busy(b_busy)
    );

    logic         in_ready_m, out_valid_m, busy_m, clear_m, start_m;
    logic [7:0]   out_data_m;
    logic [127:0] mat_m, vec_m;
    assign in_ready_m  = sel_b ? sb.in_ready  : sa.in_ready;
    assign out_valid_m = sel_b ? sb.out_valid : sa.out_valid;
    assign out_data_m  = sel_b ? sb.out_data  : sa.out_data;
    assign busy_m      = sel_b ? b_busy  : a_busy;
    assign clear_m     = sel_b ? b_clear : a_clear;
    assign start_m     = sel_b ? b_start : a_start;
    assign mat_m       = sel_b ? 128'(b_mat) : 128'(a_mat);
    assign vec_m       = sel_b ? 128'(b_vec) : 128'(a_vec);

    int n_checks = 0, n_fail = 0;
    int mvm_lat = 2;
    int a_cnt = 0, b_cnt = 0;
    int starts = 0, clears = 0, order_err = 0;
    logic a_prev_clear = 1'b0, b_prev_clear = 1'b0;
    int cur_m [16];
    int cur_v [8];
    int exp_o [6];
    int got_o [6];
    int ngot, vcyc;

    // Behavioural mvm for the 3x3 instance: answers start after mvm_lat cycles.
    always @(negedge clk) begin
        int acc;
        a_done = 1'b0;
        if (!reset) begin
            a_cnt = 0; a_prev_clear = 1'b0;
        end else begin
            if (a_clear) clears++;
            if (a_start) begin
                starts++;
                if (!a_prev_clear) order_err++;
                a_cnt = mvm_lat;
            end else if (a_cnt > 0) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    for (int r = 0; r < 3; r++) begin
                        acc = 0;
                        for (int c = 0; c < 3; c++)
                            acc += a_mat[(9-(r*3+c))*8-1 -: 8] * a_vec[(3-c)*8-1 -: 8];
                        a_res[(3-r)*8-1 -: 8] = acc[7:0];
                    end
                    a_done = 1'b1;
                end
            end
            a_prev_clear = a_clear;
        end
    end

    // Behavioural mvm for the 2x4 instance.
    always @(negedge clk) begin
        int acc;
        b_done = 1'b0;
        if (!reset) begin
            b_cnt = 0; b_prev_clear = 1'b0;
        end else begin
            if (b_clear) clears++;
            if (b_start) begin
                starts++;
                if (!b_prev_clear) order_err++;
                b_cnt = mvm_lat;
            end else if (b_cnt > 0) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    for (int r = 0; r < 2; r++) begin
                        acc = 0;
                        for (int c = 0; c < 4; c++)
                            acc += b_mat[(8-(r*4+c))*8-1 -: 8] * b_vec[(4-c)*8-1 -: 8];
                        b_res[(2-r)*8-1 -: 8] = acc[7:0];
                    end
                    b_done = 1'b1;
                end
            end
            b_prev_clear = b_clear;
        end
    end

    task automatic model(input int rows, input int dim);
        int s;
        for (int r = 0; r < rows; r++) begin
            s = 0;
            for (int c = 0; c < dim; c++) s += cur_m[r*dim+c] * cur_v[c];
            s = s % 256;
`ifdef MVM_STREAM_RELU_EN
            if (s >= 128) s = 0;
`endif
            exp_o[r] = s;
        end
    endtask

    task automatic send(input int d, input bit gaps);
        int t = 0;
        if (gaps) begin
            in_valid_d = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid_d = 1'b1;
        in_data_d  = d[7:0];
        while (!in_ready_m && t < 100) begin @(negedge clk); t++; end
        if (!in_ready_m) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready_m);
        end
        @(negedge clk);
    endtask

    task automatic collect(input int rows, input int stall_after, input string name);
        int t = 0, stall_left = 0, ready_bad = 0;
        bit holding = 1'b0;
        logic [7:0] held = 8'h00;
        ngot = 0; vcyc = 0;
        in_valid_d = 1'b1; in_data_d = 8'hEE;
        while (ngot < rows && t < 300) begin
            out_ready_d = (stall_left == 0);
            if (out_valid_m) begin
                vcyc++;
                if (holding) begin
                    n_checks++;
                    if (out_data_m !== held) begin
                        n_fail++;
                        $display("FAIL %s stall_hold: out_data=%02h required %02h", name, out_data_m, held);
                    end
                end
                if (out_ready_d) begin
                    got_o[ngot] = int'(out_data_m); ngot++; holding = 1'b0;
                    if (ngot == stall_after) stall_left = 3;
                end else begin
                    holding = 1'b1; held = out_data_m; stall_left--;
                end
            end
            if (in_ready_m) ready_bad++;
            @(negedge clk); t++;
        end
        in_valid_d = 1'b0; out_ready_d = 1'b1;
        n_checks++;
        if (ngot != rows) begin n_fail++; $display("FAIL %s beats: got %0d required %0d", name, ngot, rows); end
        n_checks++;
        if (out_valid_m !== 1'b0) begin n_fail++; $display("FAIL %s valid_drop: out_valid=%0b required 0", name, out_valid_m); end
        n_checks++;
        if (busy_m !== 1'b0) begin n_fail++; $display("FAIL %s busy_idle: busy=%0b required 0", name, busy_m); end
        n_checks++;
        if (ready_bad != 0) begin n_fail++; $display("FAIL %s in_stall: in_ready high %0d cycles required 0", name, ready_bad); end
    endtask

    // One complete operation on the selected instance against the model.
    task automatic run_op(input bit load_m, input bit gaps, input int stall_after, input bit reuse_next, input string name);
        int rows, dim, exp_cyc;
        logic [127:0] exp_bus;
        rows = sel_b ? 2 : 3;
        dim  = sel_b ? 4 : 3;
        starts = 0; clears = 0; order_err = 0;
        reuse_d = reuse_next;
        if (load_m) for (int k = 0; k < rows*dim; k++) send(cur_m[k], gaps);
        for (int c = 0; c < dim; c++) send(cur_v[c], gaps);
        in_valid_d = 1'b0;
        n_checks++;
        if (clear_m !== 1'b1) begin n_fail++; $display("FAIL %s clear_latency: mvm_clear=%0b required 1", name, clear_m); end
        n_checks++;
        if (busy_m !== 1'b1) begin n_fail++; $display("FAIL %s busy: busy=%0b required 1", name, busy_m); end
        exp_bus = '0;
        for (int k = 0; k < rows*dim; k++) exp_bus = (exp_bus << 8) | 128'(cur_m[k] & 255);
        n_checks++;
        if (mat_m !== exp_bus) begin n_fail++; $display("FAIL %s matrix_bus: got %h required %h", name, mat_m, exp_bus); end
        exp_bus = '0;
        for (int c = 0; c < dim; c++) exp_bus = (exp_bus << 8) | 128'(cur_v[c] & 255);
        n_checks++;
        if (vec_m !== exp_bus) begin n_fail++; $display("FAIL %s vector_bus: got %h required %h", name, vec_m, exp_bus); end
        @(negedge clk);
        n_checks++;
        if (start_m !== 1'b1) begin n_fail++; $display("FAIL %s start_latency: mvm_start=%0b required 1", name, start_m); end
        model(rows, dim);
        collect(rows, stall_after, name);
        for (int r = 0; r < rows; r++) begin
            n_checks++;
            if (got_o[r] != exp_o[r]) begin n_fail++; $display("FAIL %s out[%0d]: got %02h required %02h", name, r, got_o[r], exp_o[r]); end
        end
        exp_cyc = rows + ((stall_after > 0 && stall_after < rows) ? 3 : 0);
        n_checks++;
        if (vcyc != exp_cyc) begin n_fail++; $display("FAIL %s valid_cycles: got %0d required %0d", name, vcyc, exp_cyc); end
        n_checks++;
        if (starts != 1 || clears != 1 || order_err != 0) begin
            n_fail++;
            $display("FAIL %s pulses: start=%0d clear=%0d misordered=%0d required 1 1 0", name, starts, clears, order_err);
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (a_mat !== 72'h0 || a_vec !== 24'h0 || sa.out_data !== 8'h00) begin
            n_fail++; $display("FAIL %s data_zero: mat=%h vec=%h out=%h required 0", name, a_mat, a_vec, sa.out_data);
        end
        n_checks++;
        if ({sa.out_valid, sa.in_ready, a_busy, a_clear, a_start} !== 5'b0) begin
            n_fail++; $display("FAIL %s ctrl_zero: valid/ready/busy/clear/start=%05b required 00000", name,
                               {sa.out_valid, sa.in_ready, a_busy, a_clear, a_start});
        end
    endtask

    task automatic set_seq(input int m0, input int v0, input int vstep, input int rows, input int dim);
        for (int k = 0; k < rows*dim; k++) cur_m[k] = m0 + k;
        for (int c = 0; c < dim; c++) cur_v[c] = v0 + c*vstep;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid_d = 1'b1; in_data_d = 8'h5A;
        repeat (3) @(negedge clk);
        check_idle("reset");
        in_valid_d = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sa.in_ready !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: in_ready=%0b busy=%0b required 1 0", sa.in_ready, a_busy);
        end
    endtask

    task automatic test_basic();
        set_seq(1, 1, 1, 3, 3);
        run_op(1'b1, 1'b0, 0, 1'b0, "basic");
    endtask

    task automatic test_relu();
        set_seq(8'h13, 7, 1, 3, 3);
        run_op(1'b1, 1'b0, 0, 1'b0, "relu");
    endtask

    task automatic test_stall_reuse();
        set_seq(1, 1, 1, 3, 3);
        mvm_lat = 4;
        run_op(1'b1, 1'b1, 1, 1'b1, "stall");
    endtask

    task automatic test_reuse();
        set_seq(1, 3, -1, 3, 3);
        mvm_lat = 1;
        run_op(1'b0, 1'b0, 0, 1'b0, "reuse");
    endtask

    task automatic test_random(input int iters, input string name);
        bit pending = 1'b0, nxt;
        int rows, dim;
        rows = sel_b ? 2 : 3;
        dim  = sel_b ? 4 : 3;
        for (int i = 0; i < iters; i++) begin
            nxt = 1'($urandom_range(0, 1));
            mvm_lat = $urandom_range(1, 6);
            if (!pending) for (int k = 0; k < rows*dim; k++) cur_m[k] = $urandom_range(0, 255);
            for (int c = 0; c < dim; c++) cur_v[c] = $urandom_range(0, 255);
            run_op(!pending, 1'b1, $urandom_range(0, rows), (i == iters-1) ? 1'b0 : nxt, name);
            pending = (i == iters-1) ? 1'b0 : nxt;
        end
    endtask

    task automatic test_reset_midop();
        int t = 0;
        set_seq(1, 1, 1, 3, 3);
        mvm_lat = 40;
        for (int k = 0; k < 9; k++) send(cur_m[k], 1'b0);
        for (int c = 0; c < 3; c++) send(cur_v[c], 1'b0);
        in_valid_d = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_wait");
        reset = 1'b1; mvm_lat = 2;
        @(negedge clk);
        run_op(1'b1, 1'b0, 0, 1'b0, "after_wait_reset");
        for (int k = 0; k < 9; k++) send(cur_m[k], 1'b0);
        for (int c = 0; c < 3; c++) send(cur_v[c], 1'b0);
        in_valid_d = 1'b0; out_ready_d = 1'b0;
        while (!sa.out_valid && t < 100) begin @(negedge clk); t++; end
        n_checks++;
        if (sa.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_reach: out_valid=%0b required 1", sa.out_valid); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_drain");
        reset = 1'b1; out_ready_d = 1'b1;
        @(negedge clk);
        run_op(1'b1, 1'b0, 0, 1'b0, "after_drain_reset");
    endtask

    task automatic test_dim_2x4();
        sel_b = 1'b1;
        set_seq(1, 1, 1, 2, 4);
        mvm_lat = 3;
        run_op(1'b1, 1'b0, 0, 1'b0, "mvm2x4");
        test_random(4, "rand2x4");
        sel_b = 1'b0;
    endtask

    initial begin
        sel_b = 1'b0; in_valid_d = 1'b0; in_data_d = 8'h00; out_ready_d = 1'b1; reuse_d = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_relu();
        test_stall_reuse();
        test_reuse();
        test_random(8, "rand3x3");
        test_reset_midop();
        test_dim_2x4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
